// File: rtl/modport_conbus.sv
// Wishbone shared-bus interconnect: eight masters, eight slaves, one bus.
// A round-robin arbiter picks one master. Its request is broadcast to all
// slaves. The address selects one slave for cyc/stb, and that slave's
// response is routed back. Only the grant register is sequential.
module modport_conbus #(
  parameter int unsigned dw          = 32,
  parameter int unsigned aw          = 32,
  parameter int unsigned sw          = dw / 8,
  parameter int unsigned s0_addr_w   = 4,
  parameter logic [s0_addr_w-1:0] s0_addr = 4'h0,
  parameter int unsigned s1_addr_w   = 4,
  parameter logic [s1_addr_w-1:0] s1_addr = 4'h1,
  parameter int unsigned s27_addr_w  = 8,
  parameter logic [s27_addr_w-1:0] s2_addr = 8'h92,
  parameter logic [s27_addr_w-1:0] s3_addr = 8'h93,
  parameter logic [s27_addr_w-1:0] s4_addr = 8'h94,
  parameter logic [s27_addr_w-1:0] s5_addr = 8'h95,
  parameter logic [s27_addr_w-1:0] s6_addr = 8'h96,
  parameter logic [s27_addr_w-1:0] s7_addr = 8'h97
) (
  input  logic          clk,
  input  logic          rst,
  // master 0
  input  logic [dw-1:0] m0_dat_i,
  output logic [dw-1:0] m0_dat_o,
  input  logic [aw-1:0] m0_adr_i,
  input  logic [sw-1:0] m0_sel_i,
  input  logic          m0_we_i, m0_cyc_i, m0_stb_i, m0_cab_i,
  output logic          m0_ack_o, m0_err_o, m0_rty_o,
  // master 1
  input  logic [dw-1:0] m1_dat_i,
  output logic [dw-1:0] m1_dat_o,
  input  logic [aw-1:0] m1_adr_i,
  input  logic [sw-1:0] m1_sel_i,
  input  logic          m1_we_i, m1_cyc_i, m1_stb_i, m1_cab_i,
  output logic          m1_ack_o, m1_err_o, m1_rty_o,
  // master 2
  input  logic [dw-1:0] m2_dat_i,
  output logic [dw-1:0] m2_dat_o,
  input  logic [aw-1:0] m2_adr_i,
  input  logic [sw-1:0] m2_sel_i,
  input  logic          m2_we_i, m2_cyc_i, m2_stb_i, m2_cab_i,
  output logic          m2_ack_o, m2_err_o, m2_rty_o,
  // master 3
  input  logic [dw-1:0] m3_dat_i,
  output logic [dw-1:0] m3_dat_o,
  input  logic [aw-1:0] m3_adr_i,
  input  logic [sw-1:0] m3_sel_i,
  input  logic          m3_we_i, m3_cyc_i, m3_stb_i, m3_cab_i,
  output logic          m3_ack_o, m3_err_o, m3_rty_o,
  // master 4
  input  logic [dw-1:0] m4_dat_i,
  output logic [dw-1:0] m4_dat_o,
  input  logic [aw-1:0] m4_adr_i,
  input  logic [sw-1:0] m4_sel_i,
  input  logic          m4_we_i, m4_cyc_i, m4_stb_i, m4_cab_i,
  output logic          m4_ack_o, m4_err_o, m4_rty_o,
  // master 5
  input  logic [dw-1:0] m5_dat_i,
  output logic [dw-1:0] m5_dat_o,
  input  logic [aw-1:0] m5_adr_i,
  input  logic [sw-1:0] m5_sel_i,
  input  logic          m5_we_i, m5_cyc_i, m5_stb_i, m5_cab_i,
  output logic          m5_ack_o, m5_err_o, m5_rty_o,
  // master 6
  input  logic [dw-1:0] m6_dat_i,
  output logic [dw-1:0] m6_dat_o,
  input  logic [aw-1:0] m6_adr_i,
  input  logic [sw-1:0] m6_sel_i,
  input  logic          m6_we_i, m6_cyc_i, m6_stb_i, m6_cab_i,
  output logic          m6_ack_o, m6_err_o, m6_rty_o,
  // master 7
  input  logic [dw-1:0] m7_dat_i,
  output logic [dw-1:0] m7_dat_o,
  input  logic [aw-1:0] m7_adr_i,
  input  logic [sw-1:0] m7_sel_i,
  input  logic          m7_we_i, m7_cyc_i, m7_stb_i, m7_cab_i,
  output logic          m7_ack_o, m7_err_o, m7_rty_o,
  // slave 0
  input  logic [dw-1:0] s0_dat_i,
  output logic [dw-1:0] s0_dat_o,
  output logic [aw-1:0] s0_adr_o,
  output logic [sw-1:0] s0_sel_o,
  output logic          s0_we_o, s0_cyc_o, s0_stb_o, s0_cab_o,
  input  logic          s0_ack_i, s0_err_i, s0_rty_i,
  // slave 1
  input  logic [dw-1:0] s1_dat_i,
  output logic [dw-1:0] s1_dat_o,
  output logic [aw-1:0] s1_adr_o,
  output logic [sw-1:0] s1_sel_o,
  output logic          s1_we_o, s1_cyc_o, s1_stb_o, s1_cab_o,
  input  logic          s1_ack_i, s1_err_i, s1_rty_i,
  // slave 2
  input  logic [dw-1:0] s2_dat_i,
  output logic [dw-1:0] s2_dat_o,
  output logic [aw-1:0] s2_adr_o,
  output logic [sw-1:0] s2_sel_o,
  output logic          s2_we_o, s2_cyc_o, s2_stb_o, s2_cab_o,
  input  logic          s2_ack_i, s2_err_i, s2_rty_i,
  // slave 3
  input  logic [dw-1:0] s3_dat_i,
  output logic [dw-1:0] s3_dat_o,
  output logic [aw-1:0] s3_adr_o,
  output logic [sw-1:0] s3_sel_o,
  output logic          s3_we_o, s3_cyc_o, s3_stb_o, s3_cab_o,
  input  logic          s3_ack_i, s3_err_i, s3_rty_i,
  // slave 4
  input  logic [dw-1:0] s4_dat_i,
  output logic [dw-1:0] s4_dat_o,
  output logic [aw-1:0] s4_adr_o,
  output logic [sw-1:0] s4_sel_o,
  output logic          s4_we_o, s4_cyc_o, s4_stb_o, s4_cab_o,
  input  logic          s4_ack_i, s4_err_i, s4_rty_i,
  // slave 5
  input  logic [dw-1:0] s5_dat_i,
  output logic [dw-1:0] s5_dat_o,
  output logic [aw-1:0] s5_adr_o,
  output logic [sw-1:0] s5_sel_o,
  output logic          s5_we_o, s5_cyc_o, s5_stb_o, s5_cab_o,
  input  logic          s5_ack_i, s5_err_i, s5_rty_i,
  // slave 6
  input  logic [dw-1:0] s6_dat_i,
  output logic [dw-1:0] s6_dat_o,
  output logic [aw-1:0] s6_adr_o,
  output logic [sw-1:0] s6_sel_o,
  output logic          s6_we_o, s6_cyc_o, s6_stb_o, s6_cab_o,
  input  logic          s6_ack_i, s6_err_i, s6_rty_i,
  // slave 7
  input  logic [dw-1:0] s7_dat_i,
  output logic [dw-1:0] s7_dat_o,
  output logic [aw-1:0] s7_adr_o,
  output logic [sw-1:0] s7_sel_o,
  output logic          s7_we_o, s7_cyc_o, s7_stb_o, s7_cab_o,
  input  logic          s7_ack_i, s7_err_i, s7_rty_i
);

  // Gathered master-side inputs.
  logic [dw-1:0] w_m_dat [8];
  logic [aw-1:0] w_m_adr [8];
  logic [sw-1:0] w_m_sel [8];
  logic [7:0]    w_m_we, w_m_cyc, w_m_stb, w_m_cab;

  // Gathered slave-side inputs.
  logic [dw-1:0] w_s_dat [8];
  logic [7:0]    w_s_ack, w_s_err, w_s_rty;

  // Granted master's request, after the grant mux.
  logic [dw-1:0] w_dat;
  logic [aw-1:0] w_adr;
  logic [sw-1:0] w_sel;
  logic          w_we, w_cyc, w_stb, w_cab;

  logic [2:0]    r_gnt;
  logic [2:0]    w_gnt_d;
  logic [7:0]    w_hit;
  logic          w_hit_any;
  logic [2:0]    w_hit_idx;
  logic [7:0]    w_s_cyc, w_s_stb;
  logic [7:0]    w_m_ack, w_m_err, w_m_rty;
  logic [dw-1:0] w_rd_dat;

  assign w_m_dat = '{m0_dat_i, m1_dat_i, m2_dat_i, m3_dat_i,
                     m4_dat_i, m5_dat_i, m6_dat_i, m7_dat_i};
  assign w_m_adr = '{m0_adr_i, m1_adr_i, m2_adr_i, m3_adr_i,
                     m4_adr_i, m5_adr_i, m6_adr_i, m7_adr_i};
  assign w_m_sel = '{m0_sel_i, m1_sel_i, m2_sel_i, m3_sel_i,
                     m4_sel_i, m5_sel_i, m6_sel_i, m7_sel_i};
  assign w_m_we  = {m7_we_i, m6_we_i, m5_we_i, m4_we_i, m3_we_i, m2_we_i, m1_we_i, m0_we_i};
  assign w_m_cyc = {m7_cyc_i, m6_cyc_i, m5_cyc_i, m4_cyc_i,
                    m3_cyc_i, m2_cyc_i, m1_cyc_i, m0_cyc_i};
  assign w_m_stb = {m7_stb_i, m6_stb_i, m5_stb_i, m4_stb_i,
                    m3_stb_i, m2_stb_i, m1_stb_i, m0_stb_i};
  assign w_m_cab = {m7_cab_i, m6_cab_i, m5_cab_i, m4_cab_i,
                    m3_cab_i, m2_cab_i, m1_cab_i, m0_cab_i};

  assign w_s_dat = '{s0_dat_i, s1_dat_i, s2_dat_i, s3_dat_i,
                     s4_dat_i, s5_dat_i, s6_dat_i, s7_dat_i};
  assign w_s_ack = {s7_ack_i, s6_ack_i, s5_ack_i, s4_ack_i,
                    s3_ack_i, s2_ack_i, s1_ack_i, s0_ack_i};
  assign w_s_err = {s7_err_i, s6_err_i, s5_err_i, s4_err_i,
                    s3_err_i, s2_err_i, s1_err_i, s0_err_i};
  assign w_s_rty = {s7_rty_i, s6_rty_i, s5_rty_i, s4_rty_i,
                    s3_rty_i, s2_rty_i, s1_rty_i, s0_rty_i};

  // Round-robin next grant: hold while the owner keeps cyc, else first requester after it.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    w_gnt_d = r_gnt;
    found   = 1'b0;
    idx     = r_gnt;
    if (!w_m_cyc[r_gnt]) begin
      for (int k = 1; k < 8; k++) begin
        idx = r_gnt + 3'(k);
        if (!found && w_m_cyc[idx]) begin
          w_gnt_d = idx;
          found   = 1'b1;
        end
      end
    end
  end

  // Grant register; reset parks the bus on master 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gnt <= 3'd0;
    end else begin
      r_gnt <= w_gnt_d;
    end
  end

  // Request mux for the granted master.
  always_comb begin
    w_dat = w_m_dat[r_gnt];
    w_adr = w_m_adr[r_gnt];
    w_sel = w_m_sel[r_gnt];
    w_we  = w_m_we[r_gnt];
    w_cyc = w_m_cyc[r_gnt];
    w_stb = w_m_stb[r_gnt];
    w_cab = w_m_cab[r_gnt];
  end

  // Address decode; overlaps are resolved toward the lowest slave index.
  always_comb begin
    w_hit    = '0;
    w_hit[0] = (w_adr[aw-1 -: s0_addr_w] == s0_addr);
    w_hit[1] = (w_adr[aw-1 -: s1_addr_w] == s1_addr);
    w_hit[2] = (w_adr[aw-1 -: s27_addr_w] == s2_addr);
    w_hit[3] = (w_adr[aw-1 -: s27_addr_w] == s3_addr);
    w_hit[4] = (w_adr[aw-1 -: s27_addr_w] == s4_addr);
    w_hit[5] = (w_adr[aw-1 -: s27_addr_w] == s5_addr);
    w_hit[6] = (w_adr[aw-1 -: s27_addr_w] == s6_addr);
    w_hit[7] = (w_adr[aw-1 -: s27_addr_w] == s7_addr);
    w_hit_any = |w_hit;
    w_hit_idx = 3'd0;
    for (int j = 7; j >= 0; j--) begin
      if (w_hit[j]) begin
        w_hit_idx = 3'(j);
      end
    end
  end

  // Slave strobes, read data and master responses; reset forces handshakes low.
  always_comb begin
    w_s_cyc  = '0;
    w_s_stb  = '0;
    w_m_ack  = '0;
    w_m_err  = '0;
    w_m_rty  = '0;
    w_rd_dat = w_hit_any ? w_s_dat[w_hit_idx] : '0;
    if (!rst) begin
      if (w_hit_any) begin
        w_s_cyc[w_hit_idx] = w_cyc;
        w_s_stb[w_hit_idx] = w_cyc & w_stb;
        w_m_ack[r_gnt]     = w_s_ack[w_hit_idx];
        w_m_err[r_gnt]     = w_s_err[w_hit_idx];
        w_m_rty[r_gnt]     = w_s_rty[w_hit_idx];
      end else begin
        // Unmapped address: terminate the access locally with an error.
        w_m_err[r_gnt] = w_cyc & w_stb;
      end
    end
  end

  // Master-side outputs.
  assign m0_dat_o = w_rd_dat;
  assign m1_dat_o = w_rd_dat;
  assign m2_dat_o = w_rd_dat;
  assign m3_dat_o = w_rd_dat;
  assign m4_dat_o = w_rd_dat;
  assign m5_dat_o = w_rd_dat;
  assign m6_dat_o = w_rd_dat;
  assign m7_dat_o = w_rd_dat;
  assign {m7_ack_o, m6_ack_o, m5_ack_o, m4_ack_o,
          m3_ack_o, m2_ack_o, m1_ack_o, m0_ack_o} = w_m_ack;
  assign {m7_err_o, m6_err_o, m5_err_o, m4_err_o,
          m3_err_o, m2_err_o, m1_err_o, m0_err_o} = w_m_err;
  assign {m7_rty_o, m6_rty_o, m5_rty_o, m4_rty_o,
          m3_rty_o, m2_rty_o, m1_rty_o, m0_rty_o} = w_m_rty;

  // Slave-side outputs: request fields are broadcast, cyc/stb are decoded.
  assign {s0_dat_o, s1_dat_o, s2_dat_o, s3_dat_o} = {4{w_dat}};
  assign {s4_dat_o, s5_dat_o, s6_dat_o, s7_dat_o} = {4{w_dat}};
  assign {s0_adr_o, s1_adr_o, s2_adr_o, s3_adr_o} = {4{w_adr}};
  assign {s4_adr_o, s5_adr_o, s6_adr_o, s7_adr_o} = {4{w_adr}};
  assign {s0_sel_o, s1_sel_o, s2_sel_o, s3_sel_o} = {4{w_sel}};
  assign {s4_sel_o, s5_sel_o, s6_sel_o, s7_sel_o} = {4{w_sel}};
  assign {s7_we_o, s6_we_o, s5_we_o, s4_we_o, s3_we_o, s2_we_o, s1_we_o, s0_we_o} = {8{w_we}};
  assign {s7_cab_o, s6_cab_o, s5_cab_o, s4_cab_o,
          s3_cab_o, s2_cab_o, s1_cab_o, s0_cab_o} = {8{w_cab}};
  assign {s7_cyc_o, s6_cyc_o, s5_cyc_o, s4_cyc_o,
          s3_cyc_o, s2_cyc_o, s1_cyc_o, s0_cyc_o} = w_s_cyc;
  assign {s7_stb_o, s6_stb_o, s5_stb_o, s4_stb_o,
          s3_stb_o, s2_stb_o, s1_stb_o, s0_stb_o} = w_s_stb;

endmodule

// File: tb/tb_modport_conbus.sv
// Bench for modport_conbus: directed plan steps, then randomized traffic
// checked against a transaction-level model of arbitration and decode.
module tb_modport_conbus;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [31:0] m_dat_i [8];
  logic [31:0] m_dat_o [8];
  logic [31:0] m_adr   [8];
  logic [3:0]  m_sel   [8];
  logic [7:0]  m_we, m_cyc, m_stb, m_cab, m_ack, m_err, m_rty;

  logic [31:0] s_dat_i [8];
  logic [31:0] s_dat_o [8];
  logic [31:0] s_adr   [8];
  logic [3:0]  s_sel   [8];
  logic [7:0]  s_we, s_cyc, s_stb, s_cab, s_ack, s_err, s_rty;

  int checks   = 0;
  int failures = 0;
  int model_gnt = 0;

  always #5 clk = ~clk;

  modport_conbus dut (
    .clk(clk), .rst(rst),
    .m0_dat_i(m_dat_i[0]), .m0_dat_o(m_dat_o[0]), .m0_adr_i(m_adr[0]), .m0_sel_i(m_sel[0]),
    .m0_we_i(m_we[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_cab_i(m_cab[0]),
    .m0_ack_o(m_ack[0]), .m0_err_o(m_err[0]), .m0_rty_o(m_rty[0]),
    .m1_dat_i(m_dat_i[1]), .m1_dat_o(m_dat_o[1]), .m1_adr_i(m_adr[1]), .m1_sel_i(m_sel[1]),
    .m1_we_i(m_we[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_cab_i(m_cab[1]),
    .m1_ack_o(m_ack[1]), .m1_err_o(m_err[1]), .m1_rty_o(m_rty[1]),
    .m2_dat_i(m_dat_i[2]), .m2_dat_o(m_dat_o[2]), .m2_adr_i(m_adr[2]), .m2_sel_i(m_sel[2]),
    .m2_we_i(m_we[2]), .m2_cyc_i(m_cyc[2]), .m2_stb_i(m_stb[2]), .m2_cab_i(m_cab[2]),
    .m2_ack_o(m_ack[2]), .m2_err_o(m_err[2]), .m2_rty_o(m_rty[2]),
    .m3_dat_i(m_dat_i[3]), .m3_dat_o(m_dat_o[3]), .m3_adr_i(m_adr[3]), .m3_sel_i(m_sel[3]),
    .m3_we_i(m_we[3]), .m3_cyc_i(m_cyc[3]), .m3_stb_i(m_stb[3]), .m3_cab_i(m_cab[3]),
    .m3_ack_o(m_ack[3]), .m3_err_o(m_err[3]), .m3_rty_o(m_rty[3]),
    .m4_dat_i(m_dat_i[4]), .m4_dat_o(m_dat_o[4]), .m4_adr_i(m_adr[4]), .m4_sel_i(m_sel[4]),
    .m4_we_i(m_we[4]), .m4_cyc_i(m_cyc[4]), .m4_stb_i(m_stb[4]), .m4_cab_i(m_cab[4]),
    .m4_ack_o(m_ack[4]), .m4_err_o(m_err[4]), .m4_rty_o(m_rty[4]),
    .m5_dat_i(m_dat_i[5]), .m5_dat_o(m_dat_o[5]), .m5_adr_i(m_adr[5]), .m5_sel_i(m_sel[5]),
    .m5_we_i(m_we[5]), .m5_cyc_i(m_cyc[5]), .m5_stb_i(m_stb[5]), .m5_cab_i(m_cab[5]),
    .m5_ack_o(m_ack[5]), .m5_err_o(m_err[5]), .m5_rty_o(m_rty[5]),
    .m6_dat_i(m_dat_i[6]), .m6_dat_o(m_dat_o[6]), .m6_adr_i(m_adr[6]), .m6_sel_i(m_sel[6]),
    .m6_we_i(m_we[6]), .m6_cyc_i(m_cyc[6]), .m6_stb_i(m_stb[6]), .m6_cab_i(m_cab[6]),
    .m6_ack_o(m_ack[6]), .m6_err_o(m_err[6]), .m6_rty_o(m_rty[6]),
    .m7_dat_i(m_dat_i[7]), .m7_dat_o(m_dat_o[7]), .m7_adr_i(m_adr[7]), .m7_sel_i(m_sel[7]),
    .m7_we_i(m_we[7]), .m7_cyc_i(m_cyc[7]), .m7_stb_i(m_stb[7]), .m7_cab_i(m_cab[7]),
    .m7_ack_o(m_ack[7]), .m7_err_o(m_err[7]), .m7_rty_o(m_rty[7]),
    .s0_dat_i(s_dat_i[0]), .s0_dat_o(s_dat_o[0]), .s0_adr_o(s_adr[0]), .s0_sel_o(s_sel[0]),
    .s0_we_o(s_we[0]), .s0_cyc_o(s_cyc[0]), .s0_stb_o(s_stb[0]), .s0_cab_o(s_cab[0]),
    .s0_ack_i(s_ack[0]), .s0_err_i(s_err[0]), .s0_rty_i(s_rty[0]),
    .s1_dat_i(s_dat_i[1]), .s1_dat_o(s_dat_o[1]), .s1_adr_o(s_adr[1]), .s1_sel_o(s_sel[1]),
    .s1_we_o(s_we[1]), .s1_cyc_o(s_cyc[1]), .s1_stb_o(s_stb[1]), .s1_cab_o(s_cab[1]),
    .s1_ack_i(s_ack[1]), .s1_err_i(s_err[1]), .s1_rty_i(s_rty[1]),
    .s2_dat_i(s_dat_i[2]), .s2_dat_o(s_dat_o[2]), .s2_adr_o(s_adr[2]), .s2_sel_o(s_sel[2]),
    .s2_we_o(s_we[2]), .s2_cyc_o(s_cyc[2]), .s2_stb_o(s_stb[2]), .s2_cab_o(s_cab[2]),
    .s2_ack_i(s_ack[2]), .s2_err_i(s_err[2]), .s2_rty_i(s_rty[2]),
    .s3_dat_i(s_dat_i[3]), .s3_dat_o(s_dat_o[3]), .s3_adr_o(s_adr[3]), .s3_sel_o(s_sel[3]),
    .s3_we_o(s_we[3]), .s3_cyc_o(s_cyc[3]), .s3_stb_o(s_stb[3]), .s3_cab_o(s_cab[3]),
    .s3_ack_i(s_ack[3]), .s3_err_i(s_err[3]), .s3_rty_i(s_rty[3]),
    .s4_dat_i(s_dat_i[4]), .s4_dat_o(s_dat_o[4]), .s4_adr_o(s_adr[4]), .s4_sel_o(s_sel[4]),
    .s4_we_o(s_we[4]), .s4_cyc_o(s_cyc[4]), .s4_stb_o(s_stb[4]), .s4_cab_o(s_cab[4]),
    .s4_ack_i(s_ack[4]), .s4_err_i(s_err[4]), .s4_rty_i(s_rty[4]),
    .s5_dat_i(s_dat_i[5]), .s5_dat_o(s_dat_o[5]), .s5_adr_o(s_adr[5]), .s5_sel_o(s_sel[5]),
    .s5_we_o(s_we[5]), .s5_cyc_o(s_cyc[5]), .s5_stb_o(s_stb[5]), .s5_cab_o(s_cab[5]),
    .s5_ack_i(s_ack[5]), .s5_err_i(s_err[5]), .s5_rty_i(s_rty[5]),
    .s6_dat_i(s_dat_i[6]), .s6_dat_o(s_dat_o[6]), .s6_adr_o(s_adr[6]), .s6_sel_o(s_sel[6]),
    .s6_we_o(s_we[6]), .s6_cyc_o(s_cyc[6]), .s6_stb_o(s_stb[6]), .s6_cab_o(s_cab[6]),
    .s6_ack_i(s_ack[6]), .s6_err_i(s_err[6]), .s6_rty_i(s_rty[6]),
    .s7_dat_i(s_dat_i[7]), .s7_dat_o(s_dat_o[7]), .s7_adr_o(s_adr[7]), .s7_sel_o(s_sel[7]),
    .s7_we_o(s_we[7]), .s7_cyc_o(s_cyc[7]), .s7_stb_o(s_stb[7]), .s7_cab_o(s_cab[7]),
    .s7_ack_i(s_ack[7]), .s7_err_i(s_err[7]), .s7_rty_i(s_rty[7])
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Address map: slave index or -1 for unmapped.
  function automatic int decode(input logic [31:0] a);
    if (a[31:28] == 4'h0) return 0;
    if (a[31:28] == 4'h1) return 1;
    if (a[31:24] >= 8'h92 && a[31:24] <= 8'h97) return int'(a[31:24]) - 'h90;
    return -1;
  endfunction

  // Compare every DUT output against what the model predicts for the current inputs.
  task automatic check_all(input string tag);
    int g = model_gnt;
    int h = decode(m_adr[g]);
    logic [7:0]  ecyc = '0, estb = '0, eack = '0, eerr = '0, erty = '0;
    logic [31:0] edat = (h >= 0) ? s_dat_i[h] : 32'h0;
    if (!rst) begin
      if (h >= 0) begin
        ecyc[h] = m_cyc[g];
        estb[h] = m_cyc[g] & m_stb[g];
        eack[g] = s_ack[h];
        eerr[g] = s_err[h];
        erty[g] = s_rty[h];
      end else begin
        eerr[g] = m_cyc[g] & m_stb[g];
      end
    end
    chk({tag, ".s_cyc"}, 128'(s_cyc), 128'(ecyc));
    chk({tag, ".s_stb"}, 128'(s_stb), 128'(estb));
    chk({tag, ".m_ack"}, 128'(m_ack), 128'(eack));
    chk({tag, ".m_err"}, 128'(m_err), 128'(eerr));
    chk({tag, ".m_rty"}, 128'(m_rty), 128'(erty));
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("%s.s%0d_req", tag, j),
          128'({s_adr[j], s_dat_o[j], s_sel[j], s_we[j], s_cab[j]}),
          128'({m_adr[g], m_dat_i[g], m_sel[g], m_we[g], m_cab[g]}));
      chk($sformatf("%s.m%0d_dat", tag, j), 128'(m_dat_o[j]), 128'(edat));
    end
  endtask

  // Advance one clock; the model applies the arbitration rule to the pre-edge inputs.
  task automatic tick();
    int nxt = model_gnt;
    if (!m_cyc[model_gnt]) begin
      for (int k = 1; k < 8; k++) begin
        if (m_cyc[(model_gnt + k) % 8]) begin
          nxt = (model_gnt + k) % 8;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
    model_gnt = rst ? 0 : nxt;
  endtask

  task automatic idle_all();
    for (int i = 0; i < 8; i++) begin
      m_dat_i[i] = '0; m_adr[i] = '0; m_sel[i] = '0;
      s_dat_i[i] = '0;
    end
    m_we = '0; m_cyc = '0; m_stb = '0; m_cab = '0;
    s_ack = '0; s_err = '0; s_rty = '0;
  endtask

  initial begin
    logic [31:0] bases [10];
    bases = '{32'h0000_0010, 32'h1000_0020, 32'h9200_0000, 32'h9300_0004, 32'h9400_0100,
              32'h9500_0000, 32'h9600_0008, 32'h9700_000c, 32'h5000_0000, 32'h9100_0000};
    idle_all();

    // Reset: handshakes forced low even with m0 requesting.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; s_ack = 8'hff;
    #2;
    check_all("reset");
    chk("reset.s_cyc_zero", 128'(s_cyc), 128'(0));
    chk("reset.m_ack_zero", 128'(m_ack), 128'(0));
    tick();
    idle_all();
    rst = 1'b0;
    model_gnt = 0;
    #1;
    check_all("post_reset");

    // m0 single write to s0, forwarded without a grant edge.
    m_adr[0] = 32'h0000_0010; m_dat_i[0] = 32'hDEADBEEF; m_sel[0] = 4'hF;
    m_we[0] = 1'b1; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    #1;
    check_all("m0_write");
    chk("m0_write.s0_dat", 128'(s_dat_o[0]), 128'(32'hDEADBEEF));
    chk("m0_write.s_stb", 128'(s_stb), 128'(8'h01));
    s_ack[0] = 1'b1;
    #1;
    check_all("m0_write_ack");
    chk("m0_write.m_ack", 128'(m_ack), 128'(8'h01));

    // m3 read from s3 with one cycle of grant latency.
    tick();
    idle_all();
    m_adr[3] = 32'h9300_0004; m_cyc[3] = 1'b1; m_stb[3] = 1'b1; m_sel[3] = 4'hF;
    s_dat_i[3] = 32'h12345678;
    #1;
    check_all("m3_wait");
    chk("m3_wait.s_stb", 128'(s_stb), 128'(8'h00));
    tick();
    check_all("m3_granted");
    chk("m3_granted.s_stb", 128'(s_stb), 128'(8'h08));
    s_ack[3] = 1'b1;
    #1;
    check_all("m3_ack");
    chk("m3_ack.m3_dat", 128'(m_dat_o[3]), 128'(32'h12345678));
    chk("m3_ack.m_ack", 128'(m_ack), 128'(8'h08));

    // Round robin among m1, m2, m5.
    tick();
    idle_all();
    m_adr[1] = 32'h1000_0000; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    m_adr[2] = 32'h0000_0020; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    m_adr[5] = 32'h9500_0000; m_cyc[5] = 1'b1; m_stb[5] = 1'b1;
    s_ack = 8'hff;
    #1;
    check_all("rr_m1_hold0");
    chk("rr_m1_hold0.m_ack", 128'(m_ack), 128'(8'h02));
    tick();
    chk("rr_m1_hold1.m_ack", 128'(m_ack), 128'(8'h02));
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick();
    check_all("rr_m2");
    chk("rr_m2.m_ack", 128'(m_ack), 128'(8'h04));
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    chk("rr_m2_hold.m_ack", 128'(m_ack), 128'(8'h04));
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    tick();
    check_all("rr_m5");
    chk("rr_m5.m_ack", 128'(m_ack), 128'(8'h20));
    m_cyc[5] = 1'b0; m_stb[5] = 1'b0;
    tick();
    check_all("rr_m1_again");
    chk("rr_m1_again.m_ack", 128'(m_ack), 128'(8'h02));

    // Unmapped address from the granted master (m1).
    m_adr[1] = 32'h5000_0000;
    #1;
    check_all("unmapped");
    chk("unmapped.m_err", 128'(m_err), 128'(8'h02));
    chk("unmapped.s_stb", 128'(s_stb), 128'(8'h00));
    chk("unmapped.m_ack", 128'(m_ack), 128'(8'h00));

    // Reset in the middle of an m4 burst to s2.
    idle_all();
    m_adr[4] = 32'h9200_0000; m_cyc[4] = 1'b1; m_stb[4] = 1'b1; m_cab[4] = 1'b1;
    tick();
    check_all("m4_burst");
    chk("m4_burst.s_cyc", 128'(s_cyc), 128'(8'h04));
    rst = 1'b1;
    model_gnt = 0;
    #1;
    check_all("m4_rst");
    chk("m4_rst.s_cyc", 128'(s_cyc), 128'(8'h00));
    tick();
    rst = 1'b0;
    #1;
    check_all("m4_after_rst");
    chk("m4_after_rst.s_cyc", 128'(s_cyc), 128'(8'h00));
    tick();
    chk("m4_regrant.s_cyc", 128'(s_cyc), 128'(8'h04));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (m_cyc[i]) begin
          if ($urandom_range(0, 3) == 0) m_cyc[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          m_cyc[i] = 1'b1;
        end
        m_stb[i]   = m_cyc[i] & ($urandom_range(0, 3) != 0);
        m_adr[i]   = bases[$urandom_range(0, 9)] | ($urandom() & 32'h00ff_fff0 & 32'h0000_fff0);
        m_dat_i[i] = $urandom();
        m_sel[i]   = 4'($urandom());
        m_we[i]    = 1'($urandom());
        m_cab[i]   = 1'($urandom());
        s_dat_i[i] = $urandom();
      end
      s_ack = 8'($urandom()) & 8'($urandom());
      s_err = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
      s_rty = 8'($urandom()) & 8'($urandom()) & 8'($urandom());
      #1;
      check_all($sformatf("rnd%0d", n));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        model_gnt = 0;
        #1;
        check_all($sformatf("rnd%0d_rst", n));
        rst = 1'b0;
        #1;
        check_all($sformatf("rnd%0d_rel", n));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
